periph_sb_router: RTL and testbench
===================================

Name: periph_sb_router

Overview:
- Peripheral-side system-bus router between the core's data-memory port and the memory-mapped peripheral controllers (LED, switches, 7-segment, and so on).
- Decodes the core request into a one-hot request for a single device and forwards write-enable, offset address and write data.
- Captures the selected device's registered read data one cycle later.
- Detects accesses to unmapped devices, then logs and counts them.

Parameters:
- NUM_DEV, 8: number of attached peripheral controllers, 1..16.
- PERIPH_HI, 8'hFF: value of addr_i[31:24] that marks the peripheral region.
- ERR_RDATA, 32'hBAD0_ADD0: read data returned for an errored read.

Ports:
- clk_i  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_i  in  1  core bus request.
- write_enable_i  in  1  1 = write, 0 = read.
- addr_i  in  32  core byte address.
- write_data_i  in  32  core write data.
- read_data_o  out  32  read data to core.
- read_valid_o  out  1  read_data_o is fresh this cycle.
- dev_req_o  out  NUM_DEV  one-hot per-device request.
- dev_we_o  out  1  forwarded write-enable.
- dev_addr_o  out  32  device offset, {16'h0, addr_i[15:0]}.
- dev_wdata_o  out  32  forwarded write data.
- dev_rdata_i  in  32*NUM_DEV  device read data, device k at bits [32k+31:32k].
- err_o  out  1  one-cycle pulse on an errored access.
- err_addr_o  out  32  full address of the most recent errored access.
- err_cnt_o  out  8  saturating count of errored accesses.

Behaviour:
- Reset: rst is synchronous, active-high; clock clk_i. Register values after reset:
  - sel_q = 0, pend_q = 0, perr_q = 0, last_q = 0.
  - err_o = 0, err_addr_o = 0, err_cnt_o = 0.
  - Consequences: read_data_o = 0, read_valid_o = 0, dev_req_o = 0.
- Decode (combinational, same cycle as req_i):
  - in_region = (addr_i[31:24] == PERIPH_HI).
  - idx = addr_i[23:16].
  - hit = req_i & in_region & (idx < NUM_DEV).
  - bad = req_i & ~hit.
- Forward path (combinational, zero latency; devices sample at the same clk_i edge):
  - dev_req_o[idx] = hit, all other bits 0.
  - dev_we_o = write_enable_i.
  - dev_addr_o and dev_wdata_o are always driven regardless of req_i.
  - With req_i = 0, dev_req_o is all 0.
- Read tracking, at each edge when not in reset:
  - pend_q <= req_i & ~write_enable_i.
  - perr_q <= bad & ~write_enable_i.
  - sel_q <= idx[3:0] when hit, otherwise holds.
- Read data (one-cycle read latency, matching the devices' registered read ports):
  - If pend_q & ~perr_q: read_data_o = dev_rdata_i[sel_q] (combinational mux).
  - If pend_q & perr_q: read_data_o = ERR_RDATA.
  - Otherwise: read_data_o = last_q.
  - read_valid_o = pend_q.
  - last_q <= read_data_o whenever pend_q = 1, so the last returned value holds between reads.
- Back-to-back reads: reads on consecutive cycles each return their own device's data one cycle after the request. No bubbles; the router never stalls.
- Writes: produce no read_valid_o and leave last_q unchanged.
- Error logging, registered on each edge where bad = 1 (reads and writes alike):
  - err_o <= 1 for exactly one cycle after the bad access, then 0.
  - err_addr_o <= addr_i.
  - err_cnt_o <= err_cnt_o + 1, saturating at 8'hFF.
  - An errored write forwards nothing: dev_req_o stays all 0.
- Reset priority: rst has priority over everything. A read issued in the cycle rst is asserted returns nothing; read_valid_o = 0 on the next cycle.
- Simultaneous events: a bad access in the cycle after an errored read updates err_addr_o again and emits a second err_o pulse (consecutive 1s, one per bad access).

Test Plan:
1. Write 32'h0000_00A5 to addr 32'hFF00_0000 (NUM_DEV = 8) -> that cycle dev_req_o = 8'h01, dev_we_o = 1, dev_addr_o = 0, dev_wdata_o = 32'hA5; err_o stays 0.
2. Read 32'hFF03_0004 with device 3 driving 32'h1234 on the next cycle -> cycle+1: read_valid_o = 1, read_data_o = 32'h1234. Cycle+2: read_valid_o = 0, read_data_o still 32'h1234.
3. Back-to-back reads of dev 1 (returns 32'h11), then dev 2 (returns 32'h22) -> read_data_o = 32'h11 then 32'h22 on consecutive cycles, read_valid_o high for both.
4. Read 32'hFF09_0000 (idx ≥ NUM_DEV), then write to 32'h1000_0000 -> dev_req_o = 0 for both accesses.
   - Read returns 32'hBAD0_ADD0 with read_valid_o = 1.
   - err_o high for two consecutive cycles.
   - err_addr_o ends at 32'h1000_0000; err_cnt_o = 2.
5. 300 consecutive bad accesses -> err_cnt_o saturates at 8'hFF and does not wrap.
6. Issue a read of dev 0 and assert rst in the same cycle -> next cycle read_valid_o = 0, read_data_o = 0, err_cnt_o = 0. A read after rst deasserts works normally.

Source files
------------

// File: rtl/periph_sb_router_if.sv
// Core-side data-memory bus between the core and the peripheral router.
// Signals: req_i, write_enable_i, addr_i, write_data_i (core to router);
// read_data_o, read_valid_o (router to core).
interface periph_sb_router_if;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        read_valid_o;

  modport master (
    output req_i,
    output write_enable_i,
    output addr_i,
    output write_data_i,
    input  read_data_o,
    input  read_valid_o
  );

  modport slave (
    input  req_i,
    input  write_enable_i,
    input  addr_i,
    input  write_data_i,
    output read_data_o,
    output read_valid_o
  );
endinterface

// File: rtl/periph_sb_router.sv
// Peripheral system-bus router: decodes core requests to one-hot device
// requests, returns registered device read data one cycle later, and
// logs/counts accesses that hit no mapped device.
// Ports: clk_i, rst (sync, active-high); bus (core side, slave modport);
// dev_req_o/dev_we_o/dev_addr_o/dev_wdata_o forward to devices;
// dev_rdata_i packed device read data (dev k at [32k+31:32k]);
// err_o pulse, err_addr_o last bad address, err_cnt_o saturating count.
module periph_sb_router #(
  parameter int unsigned NUM_DEV   = 8,
  parameter logic [7:0]  PERIPH_HI = 8'hFF,
  parameter logic [31:0] ERR_RDATA = 32'hBAD0_ADD0
) (
  input  logic                   clk_i,
  input  logic                   rst,
  periph_sb_router_if.slave      bus,
  output logic [NUM_DEV-1:0]     dev_req_o,
  output logic                   dev_we_o,
  output logic [31:0]            dev_addr_o,
  output logic [31:0]            dev_wdata_o,
  input  logic [32*NUM_DEV-1:0]  dev_rdata_i,
  output logic                   err_o,
  output logic [31:0]            err_addr_o,
  output logic [7:0]             err_cnt_o
);

  localparam logic [7:0] NDEV = 8'(NUM_DEV);

  logic [7:0]  idx;
  logic        in_region;
  logic        hit;
  logic        bad;
  logic [31:0] rd_mux;
  logic [31:0] rdata;

  logic [3:0]  sel_q, sel_d;
  logic        pend_q, pend_d;
  logic        perr_q, perr_d;
  logic [31:0] last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [7:0]  cnt_q, cnt_d;

  assign idx       = bus.addr_i[23:16];
  assign in_region = (bus.addr_i[31:24] == PERIPH_HI);
  assign hit       = bus.req_i & in_region & (idx < NDEV);
  assign bad       = bus.req_i & ~hit;

  assign dev_we_o    = bus.write_enable_i;
  assign dev_addr_o  = {16'h0, bus.addr_i[15:0]};
  assign dev_wdata_o = bus.write_data_i;

  always_comb begin
    dev_req_o = '0;
    for (int k = 0; k < NUM_DEV; k++)
      dev_req_o[k] = hit && (idx == 8'(k));
  end

  // Device read ports are registered, so the mux uses the index
  // captured on the request cycle.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_DEV; k++)
      if (sel_q == 4'(k))
        rd_mux = dev_rdata_i[32*k +: 32];
  end

  always_comb begin
    rdata = last_q;
    if (pend_q && !perr_q)
      rdata = rd_mux;
    else if (pend_q)
      rdata = ERR_RDATA;
  end

  assign bus.read_data_o  = rdata;
  assign bus.read_valid_o = pend_q;

  always_comb begin
    pend_d  = bus.req_i & ~bus.write_enable_i;
    perr_d  = bad & ~bus.write_enable_i;
    sel_d   = hit ? idx[3:0] : sel_q;
    last_d  = pend_q ? rdata : last_q;
    err_d   = bad;
    eaddr_d = bad ? bus.addr_i : eaddr_q;
    cnt_d   = cnt_q;
    if (bad && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sel_q   <= '0;
      pend_q  <= 1'b0;
      perr_q  <= 1'b0;
      last_q  <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_o      = err_q;
  assign err_addr_o = eaddr_q;
  assign err_cnt_o  = cnt_q;

endmodule

// File: tb/tb_periph_sb_router.sv
// Directed bench for periph_sb_router: vector table plus hand-written
// saturation and reset-during-read sequences.
module tb_periph_sb_router;

  logic         clk_i = 1'b0;
  logic         rst;
  logic [7:0]   dev_req_o;
  logic         dev_we_o;
  logic [31:0]  dev_addr_o;
  logic [31:0]  dev_wdata_o;
  logic [255:0] dev_rdata_i;
  logic         err_o;
  logic [31:0]  err_addr_o;
  logic [7:0]   err_cnt_o;

  int total = 0;
  int bad = 0;

  periph_sb_router_if bus ();

  periph_sb_router dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .bus        (bus.slave),
    .dev_req_o  (dev_req_o),
    .dev_we_o   (dev_we_o),
    .dev_addr_o (dev_addr_o),
    .dev_wdata_o(dev_wdata_o),
    .dev_rdata_i(dev_rdata_i),
    .err_o      (err_o),
    .err_addr_o (err_addr_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  x_req;
    logic [31:0] x_daddr;
    logic        x_rv;
    logic [31:0] x_rd;
    logic        x_err;
    logic [7:0]  x_cnt;
    logic [31:0] x_eaddr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_i          = r;
    bus.write_enable_i = w;
    bus.addr_i         = a;
    bus.write_data_i   = d;
  endtask

  function automatic vec_t mk(
    input logic r, input logic w, input logic [31:0] a,
    input logic [31:0] d, input logic [7:0] xq, input logic [31:0] xa,
    input logic xv, input logic [31:0] xd, input logic xe,
    input logic [7:0] xc, input logic [31:0] xea);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d;
    v.x_req = xq; v.x_daddr = xa; v.x_rv = xv; v.x_rd = xd;
    v.x_err = xe; v.x_cnt = xc; v.x_eaddr = xea;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(1, 1, 32'hFF00_0000, 32'h0000_00A5, 8'h01, 32'h0,
                0, 32'h0, 0, 8'd0, 32'h0);
    tbl[1] = mk(1, 0, 32'hFF03_0004, 32'h0, 8'h08, 32'h4,
                1, 32'h1234, 0, 8'd0, 32'h0);
    tbl[2] = mk(0, 0, 32'h0, 32'h0, 8'h00, 32'h0,
                0, 32'h1234, 0, 8'd0, 32'h0);
    tbl[3] = mk(1, 0, 32'hFF01_0000, 32'h0, 8'h02, 32'h0,
                1, 32'h11, 0, 8'd0, 32'h0);
    tbl[4] = mk(1, 0, 32'hFF02_0008, 32'h0, 8'h04, 32'h8,
                1, 32'h22, 0, 8'd0, 32'h0);
    tbl[5] = mk(1, 1, 32'hFF05_ABCD, 32'hDEAD_BEEF, 8'h20, 32'hABCD,
                0, 32'h22, 0, 8'd0, 32'h0);
    tbl[6] = mk(1, 1, 32'hFF07_00FF, 32'h7, 8'h80, 32'hFF,
                0, 32'h22, 0, 8'd0, 32'h0);
    tbl[7] = mk(1, 0, 32'hFF09_0000, 32'h0, 8'h00, 32'h0,
                1, 32'hBAD0_ADD0, 1, 8'd1, 32'hFF09_0000);
    tbl[8] = mk(1, 1, 32'h1000_0000, 32'h5, 8'h00, 32'h0,
                0, 32'hBAD0_ADD0, 1, 8'd2, 32'h1000_0000);
    tbl[9] = mk(0, 0, 32'h0, 32'h0, 8'h00, 32'h0,
                0, 32'hBAD0_ADD0, 0, 8'd2, 32'h1000_0000);

    dev_rdata_i = '0;
    for (int k = 0; k < 8; k++)
      dev_rdata_i[32*k +: 32] = 32'h100 + 32'(k);
    dev_rdata_i[31:0]   = 32'hD0;
    dev_rdata_i[63:32]  = 32'h11;
    dev_rdata_i[95:64]  = 32'h22;
    dev_rdata_i[127:96] = 32'h1234;

    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rv", 32'(bus.read_valid_o), 32'h0);
    chk("rst_rd", bus.read_data_o, 32'h0);
    chk("rst_dreq", 32'(dev_req_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_ea", err_addr_o, 32'h0);
    chk("rst_cnt", 32'(err_cnt_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      #1;
      chk($sformatf("v%0d_dreq", i), 32'(dev_req_o), 32'(tbl[i].x_req));
      chk($sformatf("v%0d_dwe", i), 32'(dev_we_o), 32'(tbl[i].we));
      chk($sformatf("v%0d_dadr", i), dev_addr_o, tbl[i].x_daddr);
      chk($sformatf("v%0d_dwd", i), dev_wdata_o, tbl[i].wdata);
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_rv", i), 32'(bus.read_valid_o), 32'(tbl[i].x_rv));
      chk($sformatf("v%0d_rd", i), bus.read_data_o, tbl[i].x_rd);
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].x_err));
      chk($sformatf("v%0d_cnt", i), 32'(err_cnt_o), 32'(tbl[i].x_cnt));
      chk($sformatf("v%0d_ea", i), err_addr_o, tbl[i].x_eaddr);
    end

    // 300 back-to-back bad accesses; count starts at 2
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      drive(1, i[0], 32'h2000_0000 + 32'(i), 32'h0);
      #1;
      chk("sat_dreq", 32'(dev_req_o), 32'h0);
      @(posedge clk_i);
      #1;
      chk("sat_err", 32'(err_o), 32'h1);
      chk("sat_cnt", 32'(err_cnt_o),
          (i + 3 > 255) ? 32'hFF : 32'(i + 3));
    end
    chk("sat_ea", err_addr_o, 32'h2000_012B);

    // read issued in the reset cycle returns nothing
    @(negedge clk_i);
    rst = 1'b1;
    drive(1, 0, 32'hFF00_0000, 32'h0);
    @(posedge clk_i);
    #1;
    chk("rr_rv", 32'(bus.read_valid_o), 32'h0);
    chk("rr_rd", bus.read_data_o, 32'h0);
    chk("rr_cnt", 32'(err_cnt_o), 32'h0);
    chk("rr_err", 32'(err_o), 32'h0);
    chk("rr_ea", err_addr_o, 32'h0);
    @(negedge clk_i);
    rst = 1'b0;
    @(posedge clk_i);
    #1;
    chk("ar_rv", 32'(bus.read_valid_o), 32'h1);
    chk("ar_rd", bus.read_data_o, 32'hD0);
    @(negedge clk_i);
    drive(0, 0, 32'h0, 32'h0);
    @(posedge clk_i);
    #1;
    chk("ar_rv2", 32'(bus.read_valid_o), 32'h0);
    chk("ar_hold", bus.read_data_o, 32'hD0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
